// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-organised data RAM answering core requests after a programmable latency
// Byte-masked writes commit on the edge that enters RESP, so an access aborted by reset leaves RAM untouched.
module dmem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ip_data_addr,
   input  logic        ip_data_wr,
   input  logic [3:0]  ip_data_mask,
   input  logic [31:0] ip_data_from_proc,
   input  logic        ip_data_rd,
   output logic        op_data_valid,
   output logic [31:0] op_data_to_proc,
   output logic        op_busy
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam bit       SINGLE   = (LATENCY == 1);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t                  state_q;
   logic [3:0]              cnt_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    wr_q;
   logic [3:0]              mask_q;
   logic [31:0]             wdata_q;
   logic                    valid_q;
   logic [31:0]             rdata_q;

   logic [31:0]             mem [2**ADDR_WIDTH];

   logic                    req;
   logic                    fire;
   logic [ADDR_WIDTH-1:0]   acc_idx_d;
   logic                    acc_wr_d;
   logic [3:0]              acc_mask_d;
   logic [31:0]             acc_wdata_d;
   logic                    unused_addr_bits;

   assign unused_addr_bits = ^{ip_data_addr[31:ADDR_WIDTH+2], ip_data_addr[1:0]};
   assign req = ip_data_rd | ip_data_wr;

   // With LATENCY=1 the access happens on the acceptance edge, straight from the inputs.
   assign fire = (state_q == IDLE && req && SINGLE) || (state_q == WAIT && cnt_q == 4'd1);

   always_comb begin
      acc_idx_d   = addr_q;
      acc_wr_d    = wr_q;
      acc_mask_d  = mask_q;
      acc_wdata_d = wdata_q;
      if (state_q == IDLE) begin
         acc_idx_d   = ip_data_addr[ADDR_WIDTH+1:2];
         acc_wr_d    = ip_data_wr;
         acc_mask_d  = ip_data_mask;
         acc_wdata_d = ip_data_from_proc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         mask_q  <= 4'd0;
         wdata_q <= 32'd0;
         valid_q <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req) begin
                  addr_q  <= ip_data_addr[ADDR_WIDTH+1:2];
                  wr_q    <= ip_data_wr;
                  mask_q  <= ip_data_mask;
                  wdata_q <= ip_data_from_proc;
                  cnt_q   <= CNT_INIT;
                  state_q <= SINGLE ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_q <= RESP;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         if (fire) begin
            rdata_q <= mem[acc_idx_d];
            valid_q <= 1'b1;
         end
      end
   end

   // RAM is never cleared; the write sees the pre-write word in rdata_q on the same edge.
   always_ff @(posedge clk) begin
      if (fire && acc_wr_d && !reset) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_mask_d[i]) mem[acc_idx_d][8*i +: 8] <= acc_wdata_d[8*i +: 8];
         end
      end
   end

   assign op_data_valid   = valid_q;
   assign op_data_to_proc = rdata_q;
   assign op_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - bench for dmem_responder at LATENCY 1..4 against an array memory model
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst   [4];
   logic [31:0] a_i   [4];
   logic        wr_i  [4];
   logic        rd_i  [4];
   logic [3:0]  m_i   [4];
   logic [31:0] dat_i [4];
   logic        v_o   [4];
   logic [31:0] d_o   [4];
   logic        b_o   [4];

   int checks   = 0;
   int failures = 0;

   logic [31:0] mdl   [4][1024];
   bit          known [4][1024];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      dmem_responder #(.ADDR_WIDTH(10), .LATENCY(g + 1)) u_dut (
         .clk               (clk),
         .reset             (rst[g]),
         .ip_data_addr      (a_i[g]),
         .ip_data_wr        (wr_i[g]),
         .ip_data_mask      (m_i[g]),
         .ip_data_from_proc (dat_i[g]),
         .ip_data_rd        (rd_i[g]),
         .op_data_valid     (v_o[g]),
         .op_data_to_proc   (d_o[g]),
         .op_busy           (b_o[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] mask);
      logic [31:0] r = old;
      for (int i = 0; i < 4; i++) if (mask[i]) r[8*i +: 8] = data[8*i +: 8];
      return r;
   endfunction

   // One complete access on instance k; checks latency, data, and single-cycle valid.
   task automatic access(input int k, input logic [31:0] addr, input logic rd, input logic wr,
                         input logic [3:0] mask, input logic [31:0] data, input string tag);
      int          idx = int'((addr >> 2) % 1024);
      logic [31:0] exp = mdl[k][idx];
      bit          kn  = known[k][idx];
      int          n   = 0;
      bit          got = 0;
      if (wr) begin
         mdl[k][idx]   = merge(mdl[k][idx], data, mask);
         known[k][idx] = kn || (mask == 4'hF);
      end
      @(negedge clk);
      a_i[k] = addr; rd_i[k] = rd; wr_i[k] = wr; m_i[k] = mask; dat_i[k] = data;
      while (n < 20 && !got) begin
         @(posedge clk); #1;
         n++;
         if (v_o[k]) got = 1;
         else check({tag, "_busy"}, 32'(b_o[k]), 32'd1);
      end
      check({tag, "_lat"}, 32'(n), 32'(k + 1));
      if (kn) check({tag, "_data"}, d_o[k], exp);
      rd_i[k] = 1'b0; wr_i[k] = 1'b0;
      @(posedge clk); #1;
      check({tag, "_pulse"}, 32'(v_o[k]), 32'd0);
      check({tag, "_idle"}, 32'(b_o[k]), 32'd0);
   endtask

   initial begin
      int          n;
      bit          got;
      logic [31:0] addr;
      for (int k = 0; k < 4; k++) begin
         rst[k] = 1'b1; a_i[k] = 0; wr_i[k] = 0; rd_i[k] = 0; m_i[k] = 0; dat_i[k] = 0;
         for (int j = 0; j < 1024; j++) begin mdl[k][j] = 0; known[k][j] = 0; end
      end
      #1;
      for (int k = 0; k < 4; k++) begin
         check("rst_valid", 32'(v_o[k]), 32'd0);
         check("rst_data", d_o[k], 32'd0);
         check("rst_busy", 32'(b_o[k]), 32'd0);
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 4; k++) rst[k] = 1'b0;

      access(1, 32'h10, 0, 1, 4'hF, 32'hDEADBEEF, "wr10");
      access(1, 32'h10, 1, 0, 4'hF, 32'h0, "rd10");
      check("rd10_value", d_o[1], 32'hDEADBEEF);

      access(1, 32'h20, 0, 1, 4'hF, 32'h11223344, "pre20");
      access(1, 32'h20, 0, 1, 4'b0101, 32'hAABBCCDD, "mask20");
      access(1, 32'h20, 1, 0, 4'h0, 32'h0, "rd20");
      check("rd20_value", d_o[1], 32'h11BB33DD);
      access(1, 32'h20, 0, 1, 4'h0, 32'hFFFFFFFF, "mask0");
      access(1, 32'h20, 1, 0, 4'hF, 32'h0, "rd20b");
      check("mask0_value", d_o[1], 32'h11BB33DD);

      access(1, 32'h30, 0, 1, 4'hF, 32'h5, "pre30");
      access(1, 32'h30, 1, 1, 4'hF, 32'h9, "rw30");
      check("rw30_old", d_o[1], 32'h5);
      access(1, 32'h30, 1, 0, 4'hF, 32'h0, "rd30");
      check("rd30_new", d_o[1], 32'h9);

      access(1, 32'h1004, 0, 1, 4'hF, 32'hCAFEF00D, "wrap_wr");
      access(1, 32'h4, 1, 0, 4'hF, 32'h0, "wrap_rd");
      check("wrap_value", d_o[1], 32'hCAFEF00D);
      access(1, 32'h7, 1, 0, 4'hF, 32'h0, "low_rd");
      check("low_value", d_o[1], 32'hCAFEF00D);

      access(0, 32'h40, 0, 1, 4'hF, 32'h77777777, "l1_wr");
      @(negedge clk);
      a_i[0] = 32'h40; rd_i[0] = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         check("l1_valid", 32'(v_o[0]), 32'(i % 2));
         check("l1_busy", 32'(b_o[0]), 32'(i % 2));
         if (i % 2 == 1) check("l1_data", d_o[0], 32'h77777777);
      end
      @(negedge clk);
      rd_i[0] = 1'b0;

      access(3, 32'h44, 0, 1, 4'hF, 32'h01020304, "l4_wr");
      access(3, 32'h44, 1, 0, 4'hF, 32'h0, "l4_rd");

      access(2, 32'h50, 0, 1, 4'hF, 32'h0BADF00D, "l3_pre");
      @(negedge clk);
      a_i[2] = 32'h50; wr_i[2] = 1'b1; m_i[2] = 4'hF; dat_i[2] = 32'h12345678;
      @(posedge clk); #1;
      check("abort_busy", 32'(b_o[2]), 32'd1);
      rst[2] = 1'b1;
      #1;
      check("abort_rst_busy", 32'(b_o[2]), 32'd0);
      @(negedge clk);
      wr_i[2] = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         check("abort_novalid", 32'(v_o[2]), 32'd0);
      end
      @(negedge clk);
      rst[2] = 1'b0;
      access(2, 32'h50, 1, 0, 4'hF, 32'h0, "abort_rd");
      check("abort_old", d_o[2], 32'h0BADF00D);

      @(negedge clk);
      a_i[2] = 32'h50; rd_i[2] = 1'b1;
      n = 0; got = 0;
      while (n < 20 && !got) begin
         @(posedge clk); #1;
         n++;
         if (v_o[2]) got = 1;
      end
      check("async_seen", 32'(got), 32'd1);
      #2 rst[2] = 1'b1;
      #1;
      check("async_valid", 32'(v_o[2]), 32'd0);
      check("async_data", d_o[2], 32'd0);
      @(negedge clk);
      rd_i[2] = 1'b0; rst[2] = 1'b0;

      for (int j = 0; j < 16; j++) access(1, 32'(j * 4), 0, 1, 4'hF, $urandom, "rnd_pre");
      for (int t = 0; t < 60; t++) begin
         int op = $urandom_range(0, 2);
         addr = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
         access(1, addr, op != 1, op != 0, 4'($urandom_range(0, 15)), $urandom, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
